// File: rtl/mcu_ctrl_fsm.sv
// Purpose : frame sequencer for the MCU datapath. It loads N+2 column memories,
//           runs two processing passes over them, then drains them to the host.
// Latency : control outputs are registered and change one cycle after a decision.
//           o_wea is the exception: in LOAD it is gated combinationally by i_in_valid.
//           Read data is valid one cycle after its address.
// Backpr. : LOAD holds its counters while i_in_valid is low. PROC never stalls.
//           OUT freezes addr, memSelect and valid while o_out_valid & !i_out_ready.
//
// Ports   : i_CLK/i_RST_n    clock and asynchronous active-low reset
//           i_start          starts a frame from IDLE
//           i_in_valid/o_in_ready    input pixel handshake
//           o_out_valid/i_out_ready  output pixel handshake
//           o_state/o_substate/o_memSelect  mux-array steering
//           o_wea/o_addr     column-memory write enables and shared address
//           o_done           one-cycle pulse at frame end
// Option  : MCU_AUTO_RESTART_EN. When it is defined, a finished frame re-enters
//           LOAD directly instead of returning to IDLE.
module mcu_ctrl_fsm #(
    parameter int N            = 2,
    parameter int BITS_IMAGEN  = 11,
    parameter int IMAGE_HEIGHT = 440,
    parameter int STATES       = 3,
    parameter int ADDR_BITS    = $clog2(IMAGE_HEIGHT)
) (
    input  logic                          i_CLK,
    input  logic                          i_RST_n,
    input  logic                          i_start,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic [$clog2(STATES)-1:0]     o_state,
    output logic [$clog2(N/2+1):0]        o_substate,
    output logic [$clog2(N+2)-1:0]        o_memSelect,
    output logic [N+1:0]                  o_wea,
    output logic [ADDR_BITS-1:0]          o_addr,
    output logic                          o_done
);

    localparam int ST_W  = $clog2(STATES);
    localparam int SUB_W = $clog2(N/2+1) + 1;
    localparam int MS_W  = $clog2(N+2);
    localparam int NMEM  = N + 2;

    localparam logic [ST_W-1:0] S_LOAD = ST_W'(0);
    localparam logic [ST_W-1:0] S_PROC = ST_W'(1);
    localparam logic [ST_W-1:0] S_OUT  = ST_W'(2);
    localparam logic [ST_W-1:0] S_IDLE = ST_W'(3);

    // The mux array pairs the convolution units, so N must be even.
    if ((N % 2) != 0 || BITS_IMAGEN < 1) begin : g_bad_cfg
        $error("mcu_ctrl_fsm: N must be even and BITS_IMAGEN positive");
    end

    logic [ST_W-1:0]      state, state_nxt;
    logic [SUB_W-1:0]     substate, substate_nxt;
    logic [MS_W-1:0]      mem_sel, mem_sel_nxt;
    logic [ADDR_BITS-1:0] addr, addr_nxt;
    logic                 in_ready, in_ready_nxt;
    logic                 out_valid, out_valid_nxt;
    logic                 done, done_nxt;
    // Set once the final read address of the drain has been issued. From then on
    // the drain only waits for that last word to be accepted.
    logic                 issue_done, issue_done_nxt;

    logic xfer;
    logic out_adv;
    logic addr_last;
    logic mem_last;

    assign xfer      = i_in_valid & in_ready;
    assign out_adv   = ~out_valid | i_out_ready;
    assign addr_last = (addr == ADDR_BITS'(IMAGE_HEIGHT - 1));
    assign mem_last  = (mem_sel == MS_W'(NMEM - 1));

    // State and datapath registers
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state      <= S_IDLE;
            substate   <= '0;
            mem_sel    <= '0;
            addr       <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
            issue_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            substate   <= substate_nxt;
            mem_sel    <= mem_sel_nxt;
            addr       <= addr_nxt;
            in_ready   <= in_ready_nxt;
            out_valid  <= out_valid_nxt;
            done       <= done_nxt;
            issue_done <= issue_done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (i_start) state_nxt = S_LOAD;
            S_LOAD: if (xfer && addr_last && mem_last) state_nxt = S_PROC;
            S_PROC: if (addr_last && substate == SUB_W'(1)) state_nxt = S_OUT;
            S_OUT: begin
                // Once the last address is issued, out_valid is high, so
                // out_adv here means the last word was accepted.
                if (out_adv && issue_done) begin
`ifdef MCU_AUTO_RESTART_EN
                    state_nxt = S_LOAD;
`else
                    state_nxt = S_IDLE;
`endif
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the counters and registered outputs
    always_comb begin
        substate_nxt   = substate;
        mem_sel_nxt    = mem_sel;
        addr_nxt       = addr;
        out_valid_nxt  = out_valid;
        issue_done_nxt = issue_done;
        done_nxt       = 1'b0;
        in_ready_nxt   = (state_nxt == S_LOAD);
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    addr_nxt     = '0;
                    mem_sel_nxt  = '0;
                    substate_nxt = '0;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    if (addr_last) begin
                        addr_nxt = '0;
                        if (mem_last) begin
                            mem_sel_nxt  = '0;
                            substate_nxt = '0;
                        end else begin
                            mem_sel_nxt = mem_sel + MS_W'(1);
                        end
                    end else begin
                        addr_nxt = addr + ADDR_BITS'(1);
                    end
                end
            end
            S_PROC: begin
                if (addr_last) begin
                    addr_nxt = '0;
                    if (substate == SUB_W'(0)) begin
                        substate_nxt = SUB_W'(1);
                    end else begin
                        substate_nxt   = '0;
                        mem_sel_nxt    = '0;
                        out_valid_nxt  = 1'b0;
                        issue_done_nxt = 1'b0;
                    end
                end else begin
                    addr_nxt = addr + ADDR_BITS'(1);
                end
            end
            S_OUT: begin
                if (out_adv) begin
                    if (!issue_done) begin
                        // The address presented now has its data next cycle.
                        out_valid_nxt = 1'b1;
                        if (addr_last && mem_last) begin
                            issue_done_nxt = 1'b1;
                        end else if (addr_last) begin
                            addr_nxt    = '0;
                            mem_sel_nxt = mem_sel + MS_W'(1);
                        end else begin
                            addr_nxt = addr + ADDR_BITS'(1);
                        end
                    end else begin
                        out_valid_nxt  = 1'b0;
                        issue_done_nxt = 1'b0;
                        done_nxt       = 1'b1;
                        addr_nxt       = '0;
                        mem_sel_nxt    = '0;
                    end
                end
            end
            default: begin
                substate_nxt   = '0;
                mem_sel_nxt    = '0;
                addr_nxt       = '0;
                out_valid_nxt  = 1'b0;
                issue_done_nxt = 1'b0;
            end
        endcase
    end

    // Write enables. In LOAD, the enable is qualified by i_in_valid so that a
    // write happens only on an actual transfer cycle. In PROC, the mux array
    // writes its results back to every memory.
    always_comb begin
        o_wea = '0;
        case (state)
            S_LOAD:  o_wea = (NMEM'(1) << mem_sel) & {NMEM{i_in_valid}};
            S_PROC:  o_wea = '1;
            default: o_wea = '0;
        endcase
    end

    assign o_state     = state;
    assign o_substate  = substate;
    assign o_memSelect = mem_sel;
    assign o_addr      = addr;
    assign o_in_ready  = in_ready;
    assign o_out_valid = out_valid;
    assign o_done      = done;

endmodule

// File: tb/tb_mcu_ctrl_fsm.sv
// Directed bench for mcu_ctrl_fsm with N=2 and IMAGE_HEIGHT=4 (four memories of four words).
// Inputs are driven just after the falling edge, and outputs are checked 1 ns later.
// A frame covers reset, a full load, processing, a drain with stalls, a gapped load and a reset in PROC.
module tb_mcu_ctrl_fsm;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] state;
    logic [1:0] substate;
    logic [1:0] mem_sel;
    logic [3:0] wea;
    logic [1:0] addr;
    logic       done;

    int n_cmp;
    int n_err;
    int xfer_cnt;
    int done_cnt;

    mcu_ctrl_fsm #(
        .N(2),
        .BITS_IMAGEN(11),
        .IMAGE_HEIGHT(4),
        .STATES(3),
        .ADDR_BITS(2)
    ) dut (
        .i_CLK(clk),
        .i_RST_n(rst_n),
        .i_start(start),
        .i_in_valid(in_valid),
        .o_in_ready(in_ready),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_state(state),
        .o_substate(substate),
        .o_memSelect(mem_sel),
        .o_wea(wea),
        .o_addr(addr),
        .o_done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (in_valid === 1'b1 && in_ready === 1'b1) xfer_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".state"},     32'(state),     32'd3);
        check({tag, ".substate"},  32'(substate),  32'd0);
        check({tag, ".memSelect"}, 32'(mem_sel),   32'd0);
        check({tag, ".wea"},       32'(wea),       32'd0);
        check({tag, ".addr"},      32'(addr),      32'd0);
        check({tag, ".in_ready"},  32'(in_ready),  32'd0);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".done"},      32'(done),      32'd0);
    endtask

    initial begin
        int acc;
        int stall;
        int k;
        int cyc;
        int a;
        n_cmp = 0; n_err = 0; xfer_cnt = 0; done_cnt = 0;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        // ---- reset and idle ----
        repeat (2) @(negedge clk);
        #1 check_reset_vals("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check_reset_vals("idle_after_reset");
        end

        // ---- frame 1: continuous load ----
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("start_state", 32'(state), 32'd0);
        check("start_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("load_wea", 32'(wea), 32'(1 << (i / 4)));
            check("load_addr", 32'(addr), 32'(i % 4));
            check("load_memsel", 32'(mem_sel), 32'(i / 4));
            check("load_state", 32'(state), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        check("load_to_proc_state", 32'(state), 32'd1);
        check("load_to_proc_in_ready", 32'(in_ready), 32'd0);
        check("load_xfer_count", 32'(xfer_cnt), 32'd16);

        // ---- frame 1: processing, with start held high to confirm it is ignored ----
        start = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("proc_state", 32'(state), 32'd1);
            check("proc_substate", 32'(substate), 32'(c / 4));
            check("proc_addr", 32'(addr), 32'(c % 4));
            check("proc_wea", 32'(wea), 32'hF);
            @(negedge clk);
        end
        #1;
        check("out_entry_state", 32'(state), 32'd2);
        check("out_entry_valid", 32'(out_valid), 32'd0);
        check("out_entry_addr", 32'(addr), 32'd0);
        check("out_entry_memsel", 32'(mem_sel), 32'd0);
        check("out_entry_substate", 32'(substate), 32'd0);
        check("out_entry_wea", 32'(wea), 32'd0);
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        // ---- frame 1: drain, with a 3-cycle stall after 6 accepted words ----
        acc = 0; stall = 0; cyc = 0;
        while (acc < 16 && cyc < 60) begin
            out_ready = (acc == 6 && stall < 3) ? 1'b0 : 1'b1;
            if (!out_ready) stall++;
            #1;
            a = (acc + 1 > 15) ? 15 : acc + 1;
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_addr", 32'(addr), 32'(a % 4));
            check("out_memsel", 32'(mem_sel), 32'(a / 4));
            check("out_wea", 32'(wea), 32'd0);
            if (out_ready && out_valid === 1'b1) acc++;
            cyc++;
            @(negedge clk);
        end
        check("out_accepted", 32'(acc), 32'd16);
        out_ready = 1'b0;
        #1;
        check("frame_done_pulse", 32'(done), 32'd1);
        check("frame_done_valid", 32'(out_valid), 32'd0);
`ifdef MCU_AUTO_RESTART_EN
        check("frame_done_state", 32'(state), 32'd0);
        check("frame_done_in_ready", 32'(in_ready), 32'd1);
`else
        check("frame_done_state", 32'(state), 32'd3);
        check("frame_done_in_ready", 32'(in_ready), 32'd0);
`endif
        @(negedge clk);
        #1;
        check("done_deassert", 32'(done), 32'd0);
        check("done_count_frame1", 32'(done_cnt), 32'd1);

`ifndef MCU_AUTO_RESTART_EN
        @(negedge clk);
        #1 check("idle_wait_state", 32'(state), 32'd3);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1 check("start2_state", 32'(state), 32'd0);
`endif

        // ---- frame 2: load with gaps (valid low on every third cycle) ----
        k = 0; cyc = 0;
        while (k < 16 && cyc < 60) begin
            in_valid = (cyc % 3 != 1);
            #1;
            check("gap_wea", 32'(wea), in_valid ? 32'(1 << (k / 4)) : 32'd0);
            check("gap_addr", 32'(addr), 32'(k % 4));
            check("gap_memsel", 32'(mem_sel), 32'(k / 4));
            check("gap_state", 32'(state), 32'd0);
            if (in_valid) k++;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        check("gap_to_proc_state", 32'(state), 32'd1);
        check("gap_xfer_count", 32'(xfer_cnt), 32'd32);

        // ---- frame 2: asynchronous reset at PROC cycle 5 ----
        for (int c = 0; c < 5; c++) begin
            #1 check("proc2_addr", 32'(addr), 32'(c % 4));
            @(negedge clk);
        end
        #1;
        check("proc2_c5_state", 32'(state), 32'd1);
        check("proc2_c5_substate", 32'(substate), 32'd1);
        check("proc2_c5_addr", 32'(addr), 32'd1);
        rst_n = 1'b0;
        #1 check_reset_vals("async_reset_mid_proc");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1 check_reset_vals("after_mid_proc_reset");
        check("no_done_after_reset", 32'(done_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
